// File: rtl/shot_seq_pkg.sv
// Shared types and default widths for the shot sequencer.
package shot_seq_pkg;

  localparam int unsigned NShotWidth = 16;
  localparam int unsigned DelayWidth = 16;
  localparam int unsigned GapWidth   = 24;
  localparam int unsigned ToWidth    = 24;

  typedef enum logic [2:0] {
    StIdle,
    StRstAcc,
    StTrig,
    StDelay,
    StWaitDone,
    StGap
  } state_t;

endpackage

// File: rtl/shot_seq_cnt.sv
// Loadable down-counter; expire is a registered pulse in the cycle the count reaches one.
module shot_seq_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
    // A load of zero never expires, which lets a zero limit mean "disabled".
    expire_d = (load || en) && (cnt_d == One);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/shot_sequencer.sv
// Run-level shot controller: resetacc, per-shot trig/acq_start, procdone counting.
// Optional procdone watchdog enabled by defining SHOT_TIMEOUT_EN.
module shot_sequencer
  import shot_seq_pkg::*;
#(
  parameter int unsigned NSHOTWIDTH = NShotWidth,
  parameter int unsigned DELAYWIDTH = DelayWidth,
  parameter int unsigned GAPWIDTH   = GapWidth,
  parameter int unsigned TOWIDTH    = ToWidth
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  stb_start,
  input  logic                  stb_abort,
  input  logic [NSHOTWIDTH-1:0] nshot,
  input  logic [DELAYWIDTH-1:0] delayaftertrig,
  input  logic [GAPWIDTH-1:0]   shotgap,
  input  logic                  procdone,
`ifdef SHOT_TIMEOUT_EN
  input  logic [TOWIDTH-1:0]    timeout,
  output logic                  timedout,
`endif
  output logic                  resetacc,
  output logic                  trig,
  output logic                  acq_start,
  output logic                  busy,
  output logic [NSHOTWIDTH-1:0] shotcnt,
  output logic                  lastshotdone,
  output logic                  aborted
);

  localparam logic [NSHOTWIDTH-1:0] ShotOne = NSHOTWIDTH'(1);
  localparam logic [DELAYWIDTH-1:0] DlyOne  = DELAYWIDTH'(1);

  state_t state_q, state_d;

  logic [NSHOTWIDTH-1:0] nshot_q;
  logic [DELAYWIDTH-1:0] dly_q;
  logic [GAPWIDTH-1:0]   gap_q;

  logic resetacc_q, resetacc_d;
  logic trig_q, trig_d;
  logic busy_q, busy_d;
  logic [NSHOTWIDTH-1:0] shotcnt_q, shotcnt_d;
  logic lastshotdone_q, lastshotdone_d;
  logic aborted_q, aborted_d;

  logic dly_exp, gap_exp;
  logic start_ok, abort_ok, shot_done, last_shot;
  logic [NSHOTWIDTH-1:0] cnt_inc;

`ifdef SHOT_TIMEOUT_EN
  logic wd_exp;
  logic timedout_q, timedout_d;
`endif

  assign start_ok  = (state_q == StIdle) && stb_start && !stb_abort && (nshot != '0);
  assign abort_ok  = (state_q != StIdle) && stb_abort;
  assign shot_done = (state_q == StWaitDone) && procdone && !stb_abort;
  assign cnt_inc   = shotcnt_q + ShotOne;
  assign last_shot = (cnt_inc == nshot_q);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_ok) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (start_ok) state_d = StRstAcc;
        StRstAcc:   state_d = StTrig;
        StTrig:     state_d = StDelay;
        StDelay:    if (dly_exp) state_d = StWaitDone;
        StWaitDone: begin
          if (procdone) begin
            if (last_shot) begin
              state_d = StIdle;
            end else if (gap_q == '0) begin
              state_d = StTrig;
            end else begin
              state_d = StGap;
            end
          end
`ifdef SHOT_TIMEOUT_EN
          else if (wd_exp) begin
            state_d = StIdle;
          end
`endif
        end
        StGap:      if (gap_exp) state_d = StTrig;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    resetacc_d     = (state_d == StRstAcc);
    trig_d         = (state_d == StTrig);
    busy_d         = (state_d != StIdle);
    shotcnt_d      = shotcnt_q;
    lastshotdone_d = lastshotdone_q;
    aborted_d      = aborted_q;
`ifdef SHOT_TIMEOUT_EN
    timedout_d     = timedout_q;
`endif
    if (start_ok) begin
      shotcnt_d      = '0;
      lastshotdone_d = 1'b0;
      aborted_d      = 1'b0;
`ifdef SHOT_TIMEOUT_EN
      timedout_d     = 1'b0;
`endif
    end else if (abort_ok) begin
      aborted_d = 1'b1;
    end else if (shot_done) begin
      shotcnt_d = cnt_inc;
      if (last_shot) lastshotdone_d = 1'b1;
    end
`ifdef SHOT_TIMEOUT_EN
    else if ((state_q == StWaitDone) && wd_exp) begin
      timedout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      resetacc_q     <= 1'b0;
      trig_q         <= 1'b0;
      busy_q         <= 1'b0;
      shotcnt_q      <= '0;
      lastshotdone_q <= 1'b0;
      aborted_q      <= 1'b0;
      nshot_q        <= '0;
      dly_q          <= '0;
      gap_q          <= '0;
    end else begin
      resetacc_q     <= resetacc_d;
      trig_q         <= trig_d;
      busy_q         <= busy_d;
      shotcnt_q      <= shotcnt_d;
      lastshotdone_q <= lastshotdone_d;
      aborted_q      <= aborted_d;
      if (start_ok) begin
        nshot_q <= nshot;
        dly_q   <= (delayaftertrig == '0) ? DlyOne : delayaftertrig;
        gap_q   <= shotgap;
      end
    end
  end

  // Counters are enabled only while the FSM stays in their state, so an abort
  // can never leave a pending expire pulse behind.
  shot_seq_cnt #(
    .Width (DELAYWIDTH)
  ) u_dly_cnt (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     ((state_q == StTrig) && (state_d == StDelay)),
    .load_val (dly_q),
    .en       ((state_q == StDelay) && (state_d == StDelay)),
    .expire   (dly_exp)
  );

  shot_seq_cnt #(
    .Width (GAPWIDTH)
  ) u_gap_cnt (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     ((state_q == StWaitDone) && (state_d == StGap)),
    .load_val (gap_q),
    .en       ((state_q == StGap) && (state_d == StGap)),
    .expire   (gap_exp)
  );

`ifdef SHOT_TIMEOUT_EN
  shot_seq_cnt #(
    .Width (TOWIDTH)
  ) u_wd_cnt (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     ((state_d == StWaitDone) && (state_q != StWaitDone)),
    .load_val (timeout),
    .en       ((state_q == StWaitDone) && (state_d == StWaitDone)),
    .expire   (wd_exp)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      timedout_q <= 1'b0;
    end else begin
      timedout_q <= timedout_d;
    end
  end

  assign timedout = timedout_q;
`endif

  assign resetacc     = resetacc_q;
  assign trig         = trig_q;
  assign acq_start    = dly_exp;
  assign busy         = busy_q;
  assign shotcnt      = shotcnt_q;
  assign lastshotdone = lastshotdone_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed self-checking bench for shot_sequencer; timeout steps need SHOT_TIMEOUT_EN.
module tb_shot_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        stb_start;
  logic        stb_abort;
  logic [15:0] nshot;
  logic [15:0] delayaftertrig;
  logic [23:0] shotgap;
  logic        procdone;
  logic        resetacc;
  logic        trig;
  logic        acq_start;
  logic        busy;
  logic [15:0] shotcnt;
  logic        lastshotdone;
  logic        aborted;
`ifdef SHOT_TIMEOUT_EN
  logic [23:0] timeout;
  logic        timedout;
`endif

  int checks = 0;
  int errors = 0;
  int n_trig = 0;
  int n_rst  = 0;
  int n_acq  = 0;
  int b_trig, b_rst, b_acq;

  always #5 clk = ~clk;

  shot_sequencer u_dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .stb_start      (stb_start),
    .stb_abort      (stb_abort),
    .nshot          (nshot),
    .delayaftertrig (delayaftertrig),
    .shotgap        (shotgap),
    .procdone       (procdone),
`ifdef SHOT_TIMEOUT_EN
    .timeout        (timeout),
    .timedout       (timedout),
`endif
    .resetacc       (resetacc),
    .trig           (trig),
    .acq_start      (acq_start),
    .busy           (busy),
    .shotcnt        (shotcnt),
    .lastshotdone   (lastshotdone),
    .aborted        (aborted)
  );

  always @(posedge clk) begin
    if (trig)      n_trig <= n_trig + 1;
    if (resetacc)  n_rst  <= n_rst + 1;
    if (acq_start) n_acq  <= n_acq + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Issues a start and returns in the first trig cycle.
  task automatic start_run(input int n, input int d, input int g);
    nshot = 16'(n);
    delayaftertrig = 16'(d);
    shotgap = 24'(g);
    stb_start = 1'b1;
    step();
    stb_start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_resetacc", 32'(resetacc), 1);
    step();
  endtask

  // Called in a trig cycle; returns in the next trig cycle, or after the final shot.
  task automatic shot(input int dly, input int pdw, input int exp_cnt, input bit fin,
                      input int gap);
    check("trig", 32'(trig), 1);
    repeat (dly - 1) step();
    check("acq_early", 32'(acq_start), 0);
    step();
    check("acq_lat", 32'(acq_start), 1);
    repeat (pdw) step();
    procdone = 1'b1;
    step();
    procdone = 1'b0;
    check("shotcnt", 32'(shotcnt), 32'(exp_cnt));
    if (fin) begin
      check("lastdone", 32'(lastshotdone), 1);
      check("busy_end", 32'(busy), 0);
    end else begin
      repeat (gap) step();
    end
  endtask

  initial begin
    aresetn = 1'b0;
    stb_start = 1'b0;
    stb_abort = 1'b0;
    nshot = '0;
    delayaftertrig = '0;
    shotgap = '0;
    procdone = 1'b0;
`ifdef SHOT_TIMEOUT_EN
    timeout = '0;
`endif
    repeat (2) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_trig", 32'(trig), 0);
    check("rst_resetacc", 32'(resetacc), 0);
    check("rst_acq", 32'(acq_start), 0);
    check("rst_shotcnt", 32'(shotcnt), 0);
    check("rst_lastdone", 32'(lastshotdone), 0);
    check("rst_aborted", 32'(aborted), 0);
    aresetn = 1'b1;
    step();

    // Basic run
    b_trig = n_trig; b_rst = n_rst; b_acq = n_acq;
    start_run(3, 5, 10);
    shot(5, 4, 1, 0, 10);
    shot(5, 4, 2, 0, 10);
    shot(5, 4, 3, 1, 0);
    repeat (3) step();
    check("basic_ntrig", 32'(n_trig - b_trig), 3);
    check("basic_nrst", 32'(n_rst - b_rst), 1);
    check("basic_nacq", 32'(n_acq - b_acq), 3);

    // nshot=0 start leaves every output alone
    nshot = '0;
    stb_start = 1'b1;
    step();
    stb_start = 1'b0;
    check("zero_busy", 32'(busy), 0);
    check("zero_resetacc", 32'(resetacc), 0);
    check("zero_lastdone", 32'(lastshotdone), 1);
    check("zero_shotcnt", 32'(shotcnt), 3);
    step();
    check("zero_trig", 32'(trig), 0);

    // delay=0, gap=0, immediate procdone: trig every 3 cycles
    start_run(3, 0, 0);
    shot(1, 1, 1, 0, 0);
    shot(1, 1, 2, 0, 0);
    shot(1, 1, 3, 1, 0);

    // Abort during the second DELAY
    start_run(5, 5, 2);
    shot(5, 1, 1, 0, 2);
    check("abort_trig2", 32'(trig), 1);
    repeat (2) step();
    b_trig = n_trig; b_acq = n_acq;
    stb_abort = 1'b1;
    step();
    stb_abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_flag", 32'(aborted), 1);
    check("abort_shotcnt", 32'(shotcnt), 1);
    check("abort_lastdone", 32'(lastshotdone), 0);
    repeat (12) step();
    check("abort_no_trig", 32'(n_trig - b_trig), 0);
    check("abort_no_acq", 32'(n_acq - b_acq), 0);

    // Start while busy is ignored; nshot is latched
    b_rst = n_rst;
    nshot = 16'd2; delayaftertrig = 16'd1; shotgap = '0;
    stb_start = 1'b1;
    step();
    nshot = 16'd1;
    step();
    stb_start = 1'b0;
    check("busy_abort_clr", 32'(aborted), 0);
    shot(1, 1, 1, 0, 0);
    shot(1, 1, 2, 1, 0);
    check("busy_nrst", 32'(n_rst - b_rst), 1);

    // Abort together with procdone
    nshot = 16'd3; delayaftertrig = 16'd2; shotgap = '0;
    stb_start = 1'b1;
    step();
    stb_start = 1'b0;
    step();
    repeat (2) step();
    check("ap_acq", 32'(acq_start), 1);
    step();
    procdone = 1'b1;
    stb_abort = 1'b1;
    step();
    procdone = 1'b0;
    stb_abort = 1'b0;
    check("ap_shotcnt", 32'(shotcnt), 0);
    check("ap_aborted", 32'(aborted), 1);
    check("ap_busy", 32'(busy), 0);

    // Abort with start in IDLE: start ignored
    stb_abort = 1'b1;
    stb_start = 1'b1;
    step();
    stb_abort = 1'b0;
    stb_start = 1'b0;
    check("as_busy", 32'(busy), 0);
    check("as_resetacc", 32'(resetacc), 0);
    check("as_aborted", 32'(aborted), 1);

    // Reset mid-GAP
    start_run(3, 1, 10);
    shot(1, 1, 1, 0, 3);
    check("gap_busy", 32'(busy), 1);
    aresetn = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_shotcnt", 32'(shotcnt), 0);
    check("mrst_trig", 32'(trig), 0);
    check("mrst_resetacc", 32'(resetacc), 0);
    check("mrst_acq", 32'(acq_start), 0);
    step();
    aresetn = 1'b1;
    b_trig = n_trig;
    repeat (15) step();
    check("mrst_no_trig", 32'(n_trig - b_trig), 0);
    start_run(2, 1, 0);
    shot(1, 1, 1, 0, 0);
    shot(1, 1, 2, 1, 0);

`ifdef SHOT_TIMEOUT_EN
    // Watchdog expiry without procdone
    timeout = 24'd20;
    start_run(1, 1, 0);
    step();
    step();
    repeat (19) step();
    check("to_pre_flag", 32'(timedout), 0);
    check("to_pre_busy", 32'(busy), 1);
    step();
    check("to_flag", 32'(timedout), 1);
    check("to_busy", 32'(busy), 0);
    check("to_shotcnt", 32'(shotcnt), 0);
    // procdone in the expiry cycle wins
    start_run(1, 1, 0);
    step();
    step();
    repeat (19) step();
    procdone = 1'b1;
    step();
    procdone = 1'b0;
    check("tw_shotcnt", 32'(shotcnt), 1);
    check("tw_flag", 32'(timedout), 0);
    check("tw_lastdone", 32'(lastshotdone), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
